// File: rtl/reg_writeback_if.sv
// Register writeback bundle: ALU source, byte-serial load source, scoreboard
// and the register file write port.
interface reg_writeback_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 4
);
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_value;
  logic              alu_ready;

  logic              ld_start;
  logic [REG_AW-1:0] ld_rd;
  logic [1:0]        ld_size;
  logic              ld_unsigned;
  logic              ld_byte_valid;
  logic [7:0]        ld_byte;
  logic              ld_busy;
  logic              ld_done;

  logic              pending_valid;
  logic [REG_AW-1:0] pending_rd;

  logic [REG_AW-1:0] wb_reg;
  logic [XLEN-1:0]   wb_value;
  logic              wb_en;

  // Source side: ALU, memory unit and register-file observer
  modport master (
    output alu_valid, alu_rd, alu_value,
    output ld_start, ld_rd, ld_size, ld_unsigned, ld_byte_valid, ld_byte,
    input  alu_ready, ld_busy, ld_done, pending_valid, pending_rd,
    input  wb_reg, wb_value, wb_en
  );

  // Writeback block side
  modport slave (
    input  alu_valid, alu_rd, alu_value,
    input  ld_start, ld_rd, ld_size, ld_unsigned, ld_byte_valid, ld_byte,
    output alu_ready, ld_busy, ld_done, pending_valid, pending_rd,
    output wb_reg, wb_value, wb_en
  );
endinterface

// File: rtl/reg_writeback.sv
// Register file write-port producer: merges ALU results and byte-serial load
// results, extends loads, filters x0 and publishes a one-entry scoreboard.
// Optional feature: define REG_WRITEBACK_COUNT_EN to add the commit_count output.
module reg_writeback #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_writeback_if.slave       bus
`ifdef REG_WRITEBACK_COUNT_EN
  ,
  output logic [31:0]          commit_count
`endif
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_LCOMMIT = 2'd2
  } state_t;

  state_t            r_state, w_state_d;
  logic [REG_AW-1:0] r_rd, w_rd_d;
  logic [1:0]        r_size, w_size_d;
  logic              r_uns, w_uns_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [XLEN-1:0]   r_asm, w_asm_d;
  logic              r_wb_en, w_wb_en_d;
  logic [REG_AW-1:0] r_wb_reg, w_wb_reg_d;
  logic [XLEN-1:0]   r_wb_value, w_wb_value_d;
  logic              r_ld_done, w_ld_done_d;
  logic              r_ld_busy, w_ld_busy_d;
  logic              r_pend_valid, w_pend_valid_d;
  logic [REG_AW-1:0] r_pend_rd, w_pend_rd_d;

  logic              w_alu_ready;
  logic [CNT_W-1:0]  w_last_idx;
  logic [XLEN-1:0]   w_ext;

  // ALU stalls during the load commit cycle and on a WAW hazard with the pending load
  assign w_alu_ready = (r_state != S_LCOMMIT) &&
                       !(r_pend_valid && (bus.alu_rd == r_pend_rd));

  // Index of the final byte for the latched load size, and the extended result
  always_comb begin
    w_last_idx = CNT_W'(3);
    w_ext      = r_asm;
    case (r_size)
      2'd0: begin
        w_last_idx = CNT_W'(0);
        w_ext      = {{(XLEN-8){~r_uns & r_asm[7]}}, r_asm[7:0]};
      end
      2'd1: begin
        w_last_idx = CNT_W'(1);
        w_ext      = {{(XLEN-16){~r_uns & r_asm[15]}}, r_asm[15:0]};
      end
      default: begin
        w_last_idx = CNT_W'(3);
        w_ext      = r_asm;
      end
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_d      = r_state;
    w_rd_d         = r_rd;
    w_size_d       = r_size;
    w_uns_d        = r_uns;
    w_cnt_d        = r_cnt;
    w_asm_d        = r_asm;
    w_wb_en_d      = 1'b0;
    w_wb_reg_d     = r_wb_reg;
    w_wb_value_d   = r_wb_value;
    w_ld_done_d    = 1'b0;
    w_ld_busy_d    = r_ld_busy;
    w_pend_valid_d = r_pend_valid;
    w_pend_rd_d    = r_pend_rd;

    case (r_state)
      S_IDLE: begin
        if (bus.ld_start) begin
          w_rd_d         = bus.ld_rd;
          w_size_d       = bus.ld_size;
          w_uns_d        = bus.ld_unsigned;
          w_cnt_d        = '0;
          w_asm_d        = '0;
          w_ld_busy_d    = 1'b1;
          w_pend_valid_d = (bus.ld_rd != '0);
          w_pend_rd_d    = bus.ld_rd;
          w_state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.ld_byte_valid) begin
          w_asm_d[{r_cnt, 3'b000} +: 8] = bus.ld_byte;
          w_cnt_d = r_cnt + CNT_W'(1);
          if (r_cnt == w_last_idx) begin
            w_state_d = S_LCOMMIT;
          end
        end
      end
      S_LCOMMIT: begin
        w_wb_en_d      = (r_rd != '0);
        w_wb_reg_d     = r_rd;
        w_wb_value_d   = w_ext;
        w_ld_done_d    = 1'b1;
        w_ld_busy_d    = 1'b0;
        w_pend_valid_d = 1'b0;
        w_state_d      = S_IDLE;
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase

    // ALU transfer; never coincides with a load commit since ready is low in LCOMMIT
    if (bus.alu_valid && w_alu_ready) begin
      w_wb_en_d    = (bus.alu_rd != '0);
      w_wb_reg_d   = bus.alu_rd;
      w_wb_value_d = bus.alu_value;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rd         <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_cnt        <= '0;
      r_asm        <= '0;
      r_wb_en      <= 1'b0;
      r_wb_reg     <= '0;
      r_wb_value   <= '0;
      r_ld_done    <= 1'b0;
      r_ld_busy    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_rd    <= '0;
    end else begin
      r_state      <= w_state_d;
      r_rd         <= w_rd_d;
      r_size       <= w_size_d;
      r_uns        <= w_uns_d;
      r_cnt        <= w_cnt_d;
      r_asm        <= w_asm_d;
      r_wb_en      <= w_wb_en_d;
      r_wb_reg     <= w_wb_reg_d;
      r_wb_value   <= w_wb_value_d;
      r_ld_done    <= w_ld_done_d;
      r_ld_busy    <= w_ld_busy_d;
      r_pend_valid <= w_pend_valid_d;
      r_pend_rd    <= w_pend_rd_d;
    end
  end

  assign bus.alu_ready     = w_alu_ready;
  assign bus.ld_busy       = r_ld_busy;
  assign bus.ld_done       = r_ld_done;
  assign bus.pending_valid = r_pend_valid;
  assign bus.pending_rd    = r_pend_rd;
  assign bus.wb_reg        = r_wb_reg;
  assign bus.wb_value      = r_wb_value;
  assign bus.wb_en         = r_wb_en;

`ifdef REG_WRITEBACK_COUNT_EN
  logic [31:0] r_commit_count;

  // Count real register-file writes; wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_commit_count <= '0;
    end else if (r_wb_en) begin
      r_commit_count <= r_commit_count + 32'd1;
    end
  end

  assign commit_count = r_commit_count;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a transaction-level model predicts each
// register write and the status outputs; a monitor compares at the falling edge.
`timescale 1ns/1ps
module tb_reg_writeback;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();
`ifdef REG_WRITEBACK_COUNT_EN
  logic [31:0] commit_count;
`endif

  reg_writeback #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef REG_WRITEBACK_COUNT_EN
    ,
    .commit_count (commit_count)
`endif
  );

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] val;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Transaction-level model state
  bit          m_init = 1'b0;
  bit          m_loading, m_commit, m_busy, m_pv, exp_done, m_uns;
  int          m_nb, m_need;
  logic [3:0]  m_rd, m_prd;
  logic [31:0] m_data;
  logic [31:0] m_count = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extend(input logic [31:0] d, input int n, input bit uns);
    longint v;
    if (n == 4) return d;
    v = longint'(d);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic bit model_ready();
    return !m_commit && !(m_pv && (bus.alu_rd == m_prd));
  endfunction

  // Advance the model by one clock edge using the inputs applied before it
  task automatic model_step();
    bit  rdy;
    wb_t e;
    if (!rst_n) begin
      m_init = 1'b1; m_loading = 1'b0; m_commit = 1'b0; m_busy = 1'b0;
      m_pv = 1'b0; m_prd = 4'd0; exp_done = 1'b0; m_nb = 0; m_data = 32'd0;
      return;
    end
    rdy = model_ready();
    exp_done = 1'b0;
    if (m_commit) begin
      e.rd  = m_rd;
      e.val = extend(m_data, m_need, m_uns);
      if (m_rd != 4'd0) exp_q.push_back(e);
      exp_done = 1'b1; m_commit = 1'b0; m_busy = 1'b0; m_pv = 1'b0;
    end else if (m_loading) begin
      if (bus.ld_byte_valid) begin
        m_data = m_data + (32'(bus.ld_byte) << (8 * m_nb));
        m_nb++;
        if (m_nb == m_need) begin
          m_loading = 1'b0;
          m_commit  = 1'b1;
        end
      end
    end else if (bus.ld_start) begin
      m_loading = 1'b1; m_nb = 0; m_data = 32'd0;
      m_rd = bus.ld_rd; m_uns = bus.ld_unsigned;
      m_need = (bus.ld_size == 2'd0) ? 1 : (bus.ld_size == 2'd1) ? 2 : 4;
      m_busy = 1'b1; m_pv = (bus.ld_rd != 4'd0); m_prd = bus.ld_rd;
    end
    if (bus.alu_valid && rdy) begin
      e.rd  = bus.alu_rd;
      e.val = bus.alu_value;
      if (e.rd != 4'd0) exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = 4'd0; bus.alu_value = 32'd0;
    bus.ld_start = 1'b0; bus.ld_rd = 4'd0; bus.ld_size = 2'd0; bus.ld_unsigned = 1'b0;
    bus.ld_byte_valid = 1'b0; bus.ld_byte = 8'd0;
  endtask

  task automatic alu_one(input logic [3:0] rd, input logic [31:0] val);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_value = val;
    cyc();
    bus.alu_valid = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic do_load(input logic [3:0] rd, input logic [1:0] size, input bit uns,
                         input logic [31:0] data, input int gap);
    int n;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    bus.ld_start = 1'b1; bus.ld_rd = rd; bus.ld_size = size; bus.ld_unsigned = uns;
    cyc();
    bus.ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (gap) cyc();
      bus.ld_byte_valid = 1'b1; bus.ld_byte = data[8*i +: 8];
      cyc();
      bus.ld_byte_valid = 1'b0;
    end
    repeat (3) cyc();
  endtask

  // Monitor: every write must appear in the cycle right after the edge that produced it
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("alu_ready", 32'(bus.alu_ready), 32'(model_ready()));
        chk("ld_busy", 32'(bus.ld_busy), 32'(m_busy));
        chk("ld_done", 32'(bus.ld_done), 32'(exp_done));
        chk("pending_valid", 32'(bus.pending_valid), 32'(m_pv));
        chk("pending_rd", 32'(bus.pending_rd), 32'(m_prd));
        chk("wb_en", 32'(bus.wb_en), 32'(exp_q.size() != 0));
        if (bus.wb_en === 1'b1 && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wb_reg", 32'(bus.wb_reg), 32'(e.rd));
          chk("wb_value", bus.wb_value, e.val);
        end else if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
        end
`ifdef REG_WRITEBACK_COUNT_EN
        chk("commit_count", commit_count, m_count);
        if (bus.wb_en === 1'b1) m_count = m_count + 32'd1;
        if (!rst_n) m_count = 32'd0;
`endif
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin : driver
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    alu_one(4'd5, 32'hDEADBEEF);
    alu_one(4'd0, 32'h00001234);
    do_load(4'd3, 2'd0, 1'b0, 32'h00000080, 0);
    do_load(4'd3, 2'd0, 1'b1, 32'h00000080, 0);
    do_load(4'd9, 2'd2, 1'b0, 32'h12345678, 2);

    // WAW stall, independent ALU write during a load, stall in the commit cycle
    bus.ld_start = 1'b1; bus.ld_rd = 4'd7; bus.ld_size = 2'd2; bus.ld_unsigned = 1'b0;
    cyc();
    bus.ld_start = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_value = 32'h0000AAAA;
    repeat (2) cyc();
    bus.ld_byte_valid = 1'b1; bus.ld_byte = 8'h11;
    cyc();
    bus.ld_byte_valid = 1'b0;
    bus.alu_rd = 4'd8; bus.alu_value = 32'h00000055;
    cyc();
    bus.alu_valid = 1'b0;
    bus.ld_byte_valid = 1'b1; bus.ld_byte = 8'h22; cyc();
    bus.ld_byte = 8'h33; cyc();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_value = 32'h0000AAAA;
    bus.ld_byte = 8'h44; cyc();
    bus.ld_byte_valid = 1'b0;
    repeat (2) cyc();
    bus.alu_valid = 1'b0;
    repeat (2) cyc();

    // Reset after two of four bytes, then a signed halfword
    bus.ld_start = 1'b1; bus.ld_rd = 4'd4; bus.ld_size = 2'd2; bus.ld_unsigned = 1'b0;
    cyc();
    bus.ld_start = 1'b0;
    bus.ld_byte_valid = 1'b1; bus.ld_byte = 8'hA1; cyc();
    bus.ld_byte = 8'hA2; cyc();
    bus.ld_byte_valid = 1'b0;
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; repeat (2) cyc();
    do_load(4'd2, 2'd1, 1'b0, 32'h00007FFF, 1);

    // Randomized traffic including ignored inputs and occasional resets
    for (int i = 0; i < 4000; i++) begin
      bus.alu_valid = ($urandom_range(0, 1) == 0);
      bus.alu_rd = ($urandom_range(0, 3) == 0) ? m_prd : 4'($urandom_range(0, 15));
      bus.alu_value = $urandom;
      bus.ld_start = ($urandom_range(0, 7) == 0);
      bus.ld_rd = 4'($urandom_range(0, 15));
      bus.ld_size = 2'($urandom_range(0, 3));
      bus.ld_unsigned = 1'($urandom_range(0, 1));
      bus.ld_byte_valid = ($urandom_range(0, 1) == 0);
      bus.ld_byte = 8'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      cyc();
    end
    rst_n = 1'b1;
    idle_inputs();
    repeat (8) cyc();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
